// File: rtl/alu_md_pkg.sv
// Shared op codes, FSM state type and default datapath width for alu_md.
package alu_md_pkg;

  localparam int DEF_WIDTH = 32;

  // Mul/div ops share op[3:2]=2'b11; op[1] picks divide, op[0] picks unsigned.
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SUBU  = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;
  localparam logic [3:0] OP_MULT  = 4'd12;
  localparam logic [3:0] OP_MULTU = 4'd13;
  localparam logic [3:0] OP_DIV   = 4'd14;
  localparam logic [3:0] OP_DIVU  = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide engine: one bit per cycle on magnitudes, sign fix on the outputs.
module alu_md_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic             busy, div_r, neg_q, neg_r, dz;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, md, a_raw;

  logic             sa, sb;
  logic [WIDTH-1:0] ma, mb;
  assign sa = is_signed & a[WIDTH-1];
  assign sb = is_signed & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  // Shift-add step: acc is the upper half, q holds the multiplier shifting out.
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc} + (q[0] ? {1'b0, md} : '0);

  // Restoring-divide step: acc is the remainder, q shifts dividend out / quotient in.
  logic [WIDTH:0]   shl;
  logic             fits;
  logic [WIDTH-1:0] rsub;
  assign shl  = {acc, q[WIDTH-1]};
  assign fits = (shl >= {1'b0, md});
  assign rsub = shl[WIDTH-1:0] - md;

  assign done = busy && (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      md    <= '0;
      a_raw <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      div_r <= is_div;
      q     <= is_div ? ma : mb;
      md    <= is_div ? mb : ma;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= is_div && (b == '0);
      a_raw <= a;
    end else if (busy) begin
      cnt  <= done ? '0 : cnt + CNT_W'(1);
      busy <= !done;
      if (div_r) begin
        acc <= fits ? rsub : shl[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], fits};
      end else begin
        {acc, q} <= {msum, q[WIDTH-1:1]};
      end
    end
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  assign prod     = {acc, q};
  assign prod_fix = neg_q ? -prod : prod;

  // Divide by zero bypasses sign fix: all-ones quotient, dividend as remainder.
  always_comb begin
    hi_out = prod_fix[2*WIDTH-1:WIDTH];
    lo_out = prod_fix[WIDTH-1:0];
    if (div_r) begin
      if (dz) begin
        lo_out = '1;
        hi_out = a_raw;
      end else begin
        lo_out = neg_q ? -q : q;
        hi_out = neg_r ? -acc : acc;
      end
    end
  end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle ops plus iterative mul/div into HI/LO, valid/ready handshake.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state;

  logic accept, is_md, it_done;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_md    = (op[3:2] == 2'b11);

  alu_md_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (accept & is_md),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .a         (a),
    .b         (b),
    .done      (it_done),
    .hi_out    (it_hi),
    .lo_out    (it_lo)
  );

  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   dif;
  logic             ovf_add, ovf_sub, slt;
  assign sum     = a + b;
  assign dif     = {1'b0, a} - {1'b0, b};
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  assign slt     = dif[WIDTH-1] ^ ovf_sub;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = sum;              alu_ovf = ovf_add; end
      OP_SUB:  begin alu_res = dif[WIDTH-1:0];   alu_ovf = ovf_sub; end
      OP_SUBU: alu_res = dif[WIDTH-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          if (is_md) begin
            state <= op[1] ? ST_DIV : ST_MUL;
          end else begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
            out_valid <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: if (it_done) state <= ST_FIX;
        ST_FIX: begin
          hi        <= it_hi;
          lo        <= it_lo;
          result    <= it_lo;
          zero      <= (it_lo == '0);
          overflow  <= 1'b0;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
